alu_share_arbiter: RTL and testbench

//  Shares one combinational alu instance between two requesters: port 0 = pipeline EX-stage

---
 rtl/alu_share_arbiter.sv | 121 ++++++++++++
 tb/tb_alu_share_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Arbitrates two requesters onto one shared combinational alu.
// Operands and results are registered; each op runs IDLE -> EXEC -> RESP.
module alu_share_arbiter #(
    parameter bit FAIR = 1'b1,
    localparam int unsigned DW  = 32,
    localparam int unsigned OPW = 4
) (
    input  logic           clock,
    input  logic           resetn,

    input  logic           r0_valid,
    output logic           r0_ready,
    input  logic [DW-1:0]  r0_a,
    input  logic [DW-1:0]  r0_b,
    input  logic [OPW-1:0] r0_aluc,
    output logic           r0_rvalid,
    input  logic           r0_rready,
    output logic [DW-1:0]  r0_s,
    output logic           r0_z,

    input  logic           r1_valid,
    output logic           r1_ready,
    input  logic [DW-1:0]  r1_a,
    input  logic [DW-1:0]  r1_b,
    input  logic [OPW-1:0] r1_aluc,
    output logic           r1_rvalid,
    input  logic           r1_rready,
    output logic [DW-1:0]  r1_s,
    output logic           r1_z,

    output logic [DW-1:0]  alu_a,
    output logic [DW-1:0]  alu_b,
    output logic [OPW-1:0] alu_aluc,
    input  logic [DW-1:0]  alu_s,
    input  logic           alu_z,

    output logic           busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    logic   gnt;        // port owning the current op
    logic   ptr;        // last granted port
    logic   pick1;

    // Port 1 wins when it is alone, or on a fair tie when port 0 was served last.
    always_comb begin
        pick1    = 1'b0;
        r0_ready = 1'b0;
        r1_ready = 1'b0;
        if (r1_valid && !r0_valid) begin
            pick1 = 1'b1;
        end else if (r0_valid && r1_valid && FAIR && !ptr) begin
            pick1 = 1'b1;
        end
        if (resetn && state == IDLE) begin
            r0_ready = r0_valid && !pick1;
            r1_ready = r1_valid && pick1;
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state     <= IDLE;
            gnt       <= 1'b0;
            ptr       <= 1'b1;
            alu_a     <= DW'(0);
            alu_b     <= DW'(0);
            alu_aluc  <= OPW'(0);
            r0_s      <= DW'(0);
            r0_z      <= 1'b0;
            r0_rvalid <= 1'b0;
            r1_s      <= DW'(0);
            r1_z      <= 1'b0;
            r1_rvalid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (r0_valid || r1_valid) begin
                        alu_a    <= pick1 ? r1_a    : r0_a;
                        alu_b    <= pick1 ? r1_b    : r0_b;
                        alu_aluc <= pick1 ? r1_aluc : r0_aluc;
                        gnt      <= pick1;
                        ptr      <= pick1;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    if (gnt) begin
                        r1_s      <= alu_s;
                        r1_z      <= alu_z;
                        r1_rvalid <= 1'b1;
                    end else begin
                        r0_s      <= alu_s;
                        r0_z      <= alu_z;
                        r0_rvalid <= 1'b1;
                    end
                    state <= RESP;
                end
                RESP: begin
                    if (gnt && r1_rready) begin
                        r1_rvalid <= 1'b0;
                        state     <= IDLE;
                    end else if (!gnt && r0_rready) begin
                        r0_rvalid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: instance 0 is round-robin, instance 1 fixed priority,
// each driving its own behavioural alu; results predicted per transaction.
module tb_alu_share_arbiter;

    logic        clock;
    logic        resetn    [2];
    logic        r0_valid  [2];
    logic        r0_ready  [2];
    logic [31:0] r0_a      [2];
    logic [31:0] r0_b      [2];
    logic [3:0]  r0_aluc   [2];
    logic        r0_rvalid [2];
    logic        r0_rready [2];
    logic [31:0] r0_s      [2];
    logic        r0_z      [2];
    logic        r1_valid  [2];
    logic        r1_ready  [2];
    logic [31:0] r1_a      [2];
    logic [31:0] r1_b      [2];
    logic [3:0]  r1_aluc   [2];
    logic        r1_rvalid [2];
    logic        r1_rready [2];
    logic [31:0] r1_s      [2];
    logic        r1_z      [2];
    logic [31:0] alu_a     [2];
    logic [31:0] alu_b     [2];
    logic [3:0]  alu_aluc  [2];
    logic [31:0] alu_s     [2];
    logic        alu_z     [2];
    logic        busy      [2];

    int errors = 0;
    int checks = 0;

    // Pending request operands per instance/port, and model arbitration state.
    logic [31:0] pa [2][2];
    logic [31:0] pb [2][2];
    logic [3:0]  pc [2][2];
    int          last [2];
    bit          fair [2];

    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] c);
        case (c)
            4'b0000: return a + b;
            4'b0100: return a - b;
            4'b0001: return a & b;
            4'b0101: return a | b;
            4'b0010: return a ^ b;
            4'b0110: return {b[15:0], 16'h0000};
            4'b0011: return b << a[4:0];
            4'b0111: return b >> a[4:0];
            4'b1111: return 32'($signed(b) >>> a[4:0]);
            4'b1011: return 32'($countones(a ^ b));
            default: return 32'd0;
        endcase
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        assign alu_s[g] = alu_fn(alu_a[g], alu_b[g], alu_aluc[g]);
        assign alu_z[g] = (alu_s[g] == 32'd0);

        alu_share_arbiter #(.FAIR(g == 0)) u_dut (
            .clock    (clock),
            .resetn   (resetn[g]),
            .r0_valid (r0_valid[g]),
            .r0_ready (r0_ready[g]),
            .r0_a     (r0_a[g]),
            .r0_b     (r0_b[g]),
            .r0_aluc  (r0_aluc[g]),
            .r0_rvalid(r0_rvalid[g]),
            .r0_rready(r0_rready[g]),
            .r0_s     (r0_s[g]),
            .r0_z     (r0_z[g]),
            .r1_valid (r1_valid[g]),
            .r1_ready (r1_ready[g]),
            .r1_a     (r1_a[g]),
            .r1_b     (r1_b[g]),
            .r1_aluc  (r1_aluc[g]),
            .r1_rvalid(r1_rvalid[g]),
            .r1_rready(r1_rready[g]),
            .r1_s     (r1_s[g]),
            .r1_z     (r1_z[g]),
            .alu_a    (alu_a[g]),
            .alu_b    (alu_b[g]),
            .alu_aluc (alu_aluc[g]),
            .alu_s    (alu_s[g]),
            .alu_z    (alu_z[g]),
            .busy     (busy[g])
        );
    end

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic ready_o(input int d, input int p);
        return (p == 1) ? r1_ready[d] : r0_ready[d];
    endfunction

    function automatic logic rvalid_o(input int d, input int p);
        return (p == 1) ? r1_rvalid[d] : r0_rvalid[d];
    endfunction

    function automatic logic [31:0] s_o(input int d, input int p);
        return (p == 1) ? r1_s[d] : r0_s[d];
    endfunction

    function automatic logic z_o(input int d, input int p);
        return (p == 1) ? r1_z[d] : r0_z[d];
    endfunction

    task automatic set_valid(input int d, input int p, input logic v);
        if (p == 1) r1_valid[d] = v; else r0_valid[d] = v;
    endtask

    task automatic set_rready(input int d, input int p, input logic v);
        if (p == 1) r1_rready[d] = v; else r0_rready[d] = v;
    endtask

    task automatic set_ops(input int d, input int p, input logic [31:0] a,
                           input logic [31:0] b, input logic [3:0] c);
        if (p == 1) begin
            r1_a[d] = a; r1_b[d] = b; r1_aluc[d] = c;
        end else begin
            r0_a[d] = a; r0_b[d] = b; r0_aluc[d] = c;
        end
    endtask

    task automatic setreq(input int d, input int p, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] c);
        pa[d][p] = a; pb[d][p] = b; pc[d][p] = c;
    endtask

    // One full transaction: predicted grant, EXEC, RESP with stall, handshake.
    task automatic serve(input int d, input bit v0, input bit v1, input int stall,
                         output int w);
        logic [31:0] es;
        logic        ez;
        logic [31:0] os;
        int          o;
        w  = (v0 && v1) ? (fair[d] ? 1 - last[d] : 0) : (v1 ? 1 : 0);
        o  = 1 - w;
        es = alu_fn(pa[d][w], pb[d][w], pc[d][w]);
        ez = (es == 32'd0);
        os = s_o(d, o);
        set_ops(d, 0, pa[d][0], pb[d][0], pc[d][0]);
        set_ops(d, 1, pa[d][1], pb[d][1], pc[d][1]);
        set_valid(d, 0, v0);
        set_valid(d, 1, v1);
        set_rready(d, 0, 1'b0);
        set_rready(d, 1, 1'b0);
        #1;
        chk1("idle_ready0", ready_o(d, 0), w == 0);
        chk1("idle_ready1", ready_o(d, 1), w == 1);
        chk1("idle_busy", busy[d], 1'b0);
        @(posedge clock); #1;
        set_valid(d, w, 1'b0);
        set_ops(d, w, $urandom, $urandom, 4'($urandom));
        #1;
        chk1("exec_busy", busy[d], 1'b1);
        chk1("exec_ready_other", ready_o(d, o), 1'b0);
        chk1("exec_rvalid", rvalid_o(d, w), 1'b0);
        chk32("exec_alu_a", alu_a[d], pa[d][w]);
        chk32("exec_alu_b", alu_b[d], pb[d][w]);
        chk32("exec_alu_aluc", {28'd0, alu_aluc[d]}, {28'd0, pc[d][w]});
        @(posedge clock); #1;
        chk1("resp_rvalid", rvalid_o(d, w), 1'b1);
        chk1("resp_rvalid_other", rvalid_o(d, o), 1'b0);
        chk32("resp_s", s_o(d, w), es);
        chk1("resp_z", z_o(d, w), ez);
        chk32("resp_s_other", s_o(d, o), os);
        for (int i = 0; i < stall; i++) begin
            set_rready(d, o, 1'b1);
            @(posedge clock); #1;
            chk1("stall_rvalid", rvalid_o(d, w), 1'b1);
            chk32("stall_s", s_o(d, w), es);
            chk1("stall_busy", busy[d], 1'b1);
            chk1("stall_ready_other", ready_o(d, o), 1'b0);
            chk1("stall_rvalid_other", rvalid_o(d, o), 1'b0);
        end
        set_rready(d, o, 1'b0);
        set_rready(d, w, 1'b1);
        #1;
        chk1("hs_ready_other", ready_o(d, o), 1'b0);
        @(posedge clock); #1;
        set_rready(d, w, 1'b0);
        chk1("done_rvalid", rvalid_o(d, w), 1'b0);
        chk1("done_busy", busy[d], 1'b0);
        chk32("done_s_held", s_o(d, w), es);
        last[d] = w;
        setreq(d, w, $urandom, $urandom, 4'($urandom));
    endtask

    initial begin
        int  w;
        int  pw;
        bit  keep0;
        bit  keep1;
        bit  v0;
        bit  v1;
        fair[0] = 1'b1;
        fair[1] = 1'b0;
        for (int d = 0; d < 2; d++) begin
            resetn[d] = 1'b0;
            last[d]   = 1;
            for (int p = 0; p < 2; p++) begin
                setreq(d, p, $urandom, $urandom, 4'($urandom));
                set_ops(d, p, pa[d][p], pb[d][p], pc[d][p]);
                set_valid(d, p, 1'b1);
                set_rready(d, p, 1'b0);
            end
        end
        repeat (2) @(posedge clock);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk1("rst_ready0", r0_ready[d], 1'b0);
            chk1("rst_ready1", r1_ready[d], 1'b0);
            chk1("rst_busy", busy[d], 1'b0);
            chk1("rst_rvalid0", r0_rvalid[d], 1'b0);
            chk1("rst_rvalid1", r1_rvalid[d], 1'b0);
            chk32("rst_alu_a", alu_a[d], 32'd0);
            chk32("rst_alu_b", alu_b[d], 32'd0);
            chk32("rst_s0", r0_s[d], 32'd0);
            chk32("rst_s1", r1_s[d], 32'd0);
            chk1("rst_z0", r0_z[d], 1'b0);
            set_valid(d, 0, 1'b0);
            set_valid(d, 1, 1'b0);
            resetn[d] = 1'b1;
        end

        // Tie straight after reset: port 0 first, then port 1.
        setreq(0, 0, 32'd9, 32'd9, 4'b0100);
        setreq(0, 1, 32'h0000_00F0, 32'h0000_000F, 4'b0101);
        serve(0, 1, 1, 0, w);
        chk32("tie_sub_s", r0_s[0], 32'd0);
        chk1("tie_sub_z", r0_z[0], 1'b1);
        serve(0, 0, 1, 0, w);
        chk32("tie_or_s", r1_s[0], 32'h0000_00FF);
        chk1("tie_or_z", r1_z[0], 1'b0);

        setreq(0, 0, 32'd5, 32'd7, 4'b0000);
        serve(0, 1, 0, 0, w);
        chk32("add_s", r0_s[0], 32'd12);
        chk1("add_z", r0_z[0], 1'b0);

        setreq(0, 0, 32'd4, 32'h8000_0000, 4'b1111);
        serve(0, 1, 0, 1, w);
        chk32("sra_s", r0_s[0], 32'hF800_0000);
        setreq(0, 0, 32'd31, 32'd1, 4'b0011);
        serve(0, 1, 0, 0, w);
        chk32("sll_s", r0_s[0], 32'h8000_0000);

        // Backpressure on port 1 while port 0 waits.
        setreq(0, 1, 32'hFFFF_0000, 32'd0, 4'b1011);
        setreq(0, 0, 32'd3, 32'd4, 4'b0000);
        serve(0, 1, 1, 5, w);
        chk32("hamd_s", r1_s[0], 32'd16);
        serve(0, 1, 0, 0, w);
        chk32("hamd_next_s", r0_s[0], 32'd7);

        // Continuous contention, round-robin.
        pw = last[0];
        for (int i = 0; i < 6; i++) begin
            serve(0, 1, 1, $urandom_range(0, 2), w);
            chk1("rr_alternate", ready_o(0, w) | (w != pw), 1'b1);
            pw = w;
        end
        serve(0, 0, 1, 0, w);

        // Random traffic; a port left waiting keeps its request up.
        keep0 = 1'b0;
        keep1 = 1'b0;
        for (int i = 0; i < 24; i++) begin
            v0 = keep0 | ($urandom_range(0, 1) == 1);
            v1 = keep1 | ($urandom_range(0, 1) == 1);
            if (!v0 && !v1) v1 = 1'b1;
            serve(0, v0, v1, $urandom_range(0, 3), w);
            keep0 = v0 && (w != 0);
            keep1 = v1 && (w != 1);
        end
        if (keep0) serve(0, 1, 0, 0, w);
        if (keep1) serve(0, 0, 1, 0, w);

        // Fixed priority instance: port 0 takes every tie.
        for (int i = 0; i < 6; i++) begin
            serve(1, 1, 1, $urandom_range(0, 1), w);
        end
        serve(1, 0, 1, 0, w);

        // Reset while EXEC, with both ports requesting during reset.
        setreq(0, 0, 32'd100, 32'd23, 4'b0000);
        set_ops(0, 0, pa[0][0], pb[0][0], pc[0][0]);
        set_valid(0, 0, 1'b1);
        #1;
        chk1("pre_rst_ready", r0_ready[0], 1'b1);
        @(posedge clock); #1;
        chk1("pre_rst_busy", busy[0], 1'b1);
        resetn[0] = 1'b0;
        set_valid(0, 1, 1'b1);
        #1;
        chk1("in_rst_ready0", r0_ready[0], 1'b0);
        chk1("in_rst_ready1", r1_ready[0], 1'b0);
        @(posedge clock); #1;
        chk1("post_rst_busy", busy[0], 1'b0);
        chk1("post_rst_rvalid0", r0_rvalid[0], 1'b0);
        chk1("post_rst_rvalid1", r1_rvalid[0], 1'b0);
        chk32("post_rst_alu_a", alu_a[0], 32'd0);
        chk32("post_rst_alu_b", alu_b[0], 32'd0);
        chk32("post_rst_aluc", {28'd0, alu_aluc[0]}, 32'd0);
        chk32("post_rst_s0", r0_s[0], 32'd0);
        chk32("post_rst_s1", r1_s[0], 32'd0);
        set_valid(0, 0, 1'b0);
        resetn[0] = 1'b1;
        last[0] = 1;
        serve(0, 0, 1, 1, w);
        chk1("rst_no_reserve", r0_rvalid[0], 1'b0);
        setreq(0, 0, 32'd100, 32'd23, 4'b0000);
        serve(0, 1, 0, 0, w);
        chk32("rst_fresh_s", r0_s[0], 32'd123);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
